softmax_arb: RTL and testbench
==============================

# softmax_arb

Round-robin arbiter and sequencer that shares one `softmax` engine (D_W=16, NUM=16) among N_REQ requesters, e.g. the per-head attention-score rows of the MHA datapath. It selects a requester and drives the engine's hold-while-computing start/data interface. It captures the engine's one-cycle result pulse and returns the result with a per-requester done pulse. It also recovers from requester aborts and engine hangs.

## Interface
- D_W, 16, element width (must match engine)
- NUM, 16, elements per vector (must match engine)
- N_REQ, 4, number of requesters (2..16)
- TIMEOUT, 1024, max RUN cycles before abort with error
- I_CLK  in  1  clock; all logic on rising edge
- I_RST_N  in  1  asynchronous active-low reset
- I_REQ  in  N_REQ  per-requester request; held with data until own O_DONE/O_ERR
- I_REQ_DATA  in  N_REQ*D_W*NUM  requester k vector at [k*D_W*NUM +: D_W*NUM]
- O_GNT  out  N_REQ  one-hot grant, high for whole service
- O_DONE  out  N_REQ  one-cycle completion pulse for the served requester
- O_ERR  out  1  one-cycle timeout pulse
- O_ID  out  $clog2(N_REQ)  index of last completed/errored requester
- O_DATA  out  D_W*NUM  last softmax result, held until next completion
- O_SM_START  out  1  engine start, held during computation
- O_SM_DATA  out  D_W*NUM  engine input vector
- I_SM_VLD  in  1  engine result-valid pulse
- I_SM_DATA  in  D_W*NUM  engine result

## Operation
- States: S_IDLE, S_RUN, S_GAP. All outputs reset to 0. `last` pointer resets to N_REQ-1, so requester 0 has first priority. Timeout counter resets to 0.
- **S_IDLE:** if I_REQ≠0, pick the first set bit searching from last+1 upward with wrap. Latch it as `cur`, set O_GNT[cur], clear the counter, go to S_RUN. Otherwise stay.
- **S_RUN:**
  - O_SM_START = run & ~I_SM_VLD (combinational gate), so the engine sees start low in the cycle its valid is high and does not restart.
  - O_SM_DATA = I_REQ_DATA slice `cur` (combinational mux on latched `cur`). It is 0 outside S_RUN.
  - Counter increments every RUN cycle.
- **Completion (I_SM_VLD=1 in S_RUN):**
  - Register O_DATA <= I_SM_DATA, O_ID <= cur, O_DONE[cur] <= 1, O_GNT <= 0, last <= cur.
  - Go to S_GAP.
- **Abort (I_REQ[cur]=0 in S_RUN, no I_SM_VLD):** O_GNT <= 0, last <= cur, go to S_GAP. No O_DONE, no O_ERR; O_DATA and O_ID unchanged.
- **Timeout (counter == TIMEOUT-1, no I_SM_VLD):** O_ERR <= 1, O_ID <= cur, O_GNT <= 0, last <= cur, go to S_GAP. O_DATA unchanged.
- **S_GAP:** one cycle with O_SM_START=0, which returns the engine to idle from any state. O_DONE and O_ERR clear. Go to S_IDLE.
- **Priority in one cycle:** completion > abort > timeout.
- Requests arriving while not in S_IDLE are ignored until S_IDLE. Non-granted requests are never dropped; they wait.
- Counter width is $clog2(TIMEOUT+1) and saturates; it never wraps.
- Reset mid-operation: all state returns to reset values immediately and O_SM_START drops asynchronously.

## Timing
- I_REQ sampled in S_IDLE at edge t: O_GNT and O_SM_START high from t+1.
- I_SM_VLD high in cycle v:
  - O_SM_START low in v.
  - O_DONE, O_ID and O_DATA valid in v+1; O_GNT low in v+1.
  - S_GAP in v+1, S_IDLE in v+2, next grant visible earliest in v+3.
- Back-to-back service overhead: 3 cycles beyond engine latency.
- O_DONE and O_ERR are exactly one cycle wide; at most one bit of O_DONE is set.
- Fairness: with all N_REQ requesting continuously, each is served once per N_REQ services, in index order.

## Test plan
- **Reset:** hold I_RST_N=0 with I_REQ=4'b1111. Then: all outputs 0. After release, first grant O_GNT=4'b0001.
- **Single request:** I_REQ=4'b0100, engine model returns I_SM_VLD 40 cycles after start with I_SM_DATA=A. Then: O_GNT=4'b0100 for 40 cycles; O_DONE=4'b0100 for one cycle with O_DATA=A, O_ID=2; O_SM_START low in the I_SM_VLD cycle.
- **Round-robin:** I_REQ=4'b1111 held, each requester re-raising after its done. Then: grant order 0,1,2,3,0; 3 idle cycles between each I_SM_VLD and the next O_SM_START rise.
- **Abort:** requester 1 drops I_REQ at RUN cycle 10. Then: no O_DONE, no O_ERR; O_SM_START low for ≥1 cycle; pending requester 2 granted next.
- **Timeout:** TIMEOUT=64, engine never asserts valid. Then: O_ERR=1 for one cycle at RUN cycle 64 with O_ID=cur; O_DATA unchanged; next requester granted.
- **Simultaneous events:** I_SM_VLD in the same cycle as I_REQ[cur] drop and as counter==TIMEOUT-1. Then: completion wins, O_DONE pulses, O_ERR=0.

Source files
------------

// File: rtl/softmax_arb_if.sv
// Requester/engine bundle around the softmax arbiter: request vectors in, grant/done/result out,
// plus the hold-while-computing start/data link to the shared engine and its one-cycle result pulse.
interface softmax_arb_if #(
   parameter int D_W   = 16,
   parameter int NUM   = 16,
   parameter int N_REQ = 4
);
   localparam int VW = D_W * NUM;
   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*VW-1:0] req_data;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic                err;
   logic [IW-1:0]       id;
   logic [VW-1:0]       data;
   logic                sm_start;
   logic [VW-1:0]       sm_data;
   logic                sm_vld;
   logic [VW-1:0]       sm_res;

   modport master (
      output req, req_data, sm_vld, sm_res,
      input  gnt, done, err, id, data, sm_start, sm_data
   );

   modport slave (
      input  req, req_data, sm_vld, sm_res,
      output gnt, done, err, id, data, sm_start, sm_data
   );
endinterface

// File: rtl/softmax_arb.sv
// Round-robin share of one softmax engine: grant 1 cycle after request, result/done 1 cycle after engine valid,
// 3-cycle turnaround; requesters hold req+data until their done/err, losers simply wait (no drop).
module softmax_arb #(
   parameter int D_W     = 16,
   parameter int NUM     = 16,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1024
) (
   input logic          clk,
   input logic          rst_n,
   softmax_arb_if.slave bus
);
   localparam int VW = D_W * NUM;
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IW-1:0]    cur;
   logic [IW-1:0]    last;
   logic [IW-1:0]    pick;
   logic             pick_vld;
   logic [CW-1:0]    cnt;
   logic             run;
   logic             cur_req;
   logic             hit_done;
   logic             hit_abort;
   logic             hit_tout;
   logic             finish;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] done_q;
   logic             err_q;
   logic [IW-1:0]    id_q;
   logic [VW-1:0]    data_q;

   assign run     = (state == S_RUN);
   assign cur_req = bus.req[cur];
   assign finish  = hit_done | hit_abort | hit_tout;

   // Search starts just after the last served index so every requester gets a turn.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = last;
      pick_vld = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = int'(last) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!pick_vld && bus.req[idx]) begin
            pick     = IW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hit_done  = 1'b0;
      hit_abort = 1'b0;
      hit_tout  = 1'b0;
      case (state)
         S_IDLE: if (pick_vld) state_nxt = S_RUN;
         S_RUN: begin
            if (bus.sm_vld)            hit_done  = 1'b1;
            else if (!cur_req)         hit_abort = 1'b1;
            else if (cnt == CNT_LAST)  hit_tout  = 1'b1;
            if (hit_done || hit_abort || hit_tout) state_nxt = S_GAP;
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur    <= '0;
         last   <= IW'(N_REQ - 1);
         cnt    <= '0;
         gnt_q  <= '0;
         done_q <= '0;
         err_q  <= 1'b0;
         id_q   <= '0;
         data_q <= '0;
      end else begin
         done_q <= '0;
         err_q  <= 1'b0;
         if (state == S_IDLE && pick_vld) begin
            cur   <= pick;
            gnt_q <= N_REQ'(1) << pick;
            cnt   <= '0;
         end else if (run && cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
         if (hit_done) begin
            data_q <= bus.sm_res;
            id_q   <= cur;
            done_q <= N_REQ'(1) << cur;
         end
         if (hit_tout) begin
            err_q <= 1'b1;
            id_q  <= cur;
         end
         if (finish) begin
            gnt_q <= '0;
            last  <= cur;
         end
      end
   end

   // Start drops in the valid cycle so the engine cannot re-launch on the same vector.
   assign bus.sm_start = run & ~bus.sm_vld;
   assign bus.sm_data  = run ? bus.req_data[int'(cur)*VW +: VW] : '0;
   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.id       = id_q;
   assign bus.data     = data_q;

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
   a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));
endmodule

// File: tb/tb_softmax_arb.sv
// Directed bench for softmax_arb with a small latency-programmable engine model.
module tb_softmax_arb;
   localparam int D_W = 16, NUM = 16, N_REQ = 4, TIMEOUT = 64;
   localparam int VW = D_W * NUM;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   softmax_arb_if #(.D_W(D_W), .NUM(NUM), .N_REQ(N_REQ)) bus ();

   softmax_arb #(.D_W(D_W), .NUM(NUM), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int eng_lat = 0;
   int eng_cnt = 0;
   logic [VW-1:0] eng_res = '0;

   function automatic logic [VW-1:0] vec(input int k);
      logic [VW-1:0] v;
      v = '0;
      for (int e = 0; e < NUM; e++) v[e*D_W +: D_W] = D_W'(16'h1000 * (k + 1) + e);
      return v;
   endfunction

   // Engine: valid pulses in the eng_lat-th cycle of continuous start; eng_lat=0 never answers.
   initial begin
      bus.sm_vld = 1'b0;
      bus.sm_res = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.sm_vld = 1'b0;
         if (!bus.sm_start) eng_cnt = 0;
         else begin
            eng_cnt++;
            if (eng_lat != 0 && eng_cnt == eng_lat) begin
               bus.sm_vld = 1'b1;
               bus.sm_res = eng_res;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      eng_lat = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = 4'b1111;
      eng_lat = 0;
      repeat (3) @(negedge clk);
      checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
      checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      checks++; if (bus.id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.id); end
      checks++; if (bus.data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.data); end
      checks++; if (bus.sm_start !== 1'b0) begin failures++; $display("FAIL reset_sm_start got=%b exp=0", bus.sm_start); end
      checks++; if (bus.sm_data !== '0) begin failures++; $display("FAIL reset_sm_data got=%h exp=0", bus.sm_data); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt got=%b exp=0001", bus.gnt); end
      checks++; if (bus.sm_start !== 1'b1) begin failures++; $display("FAIL reset_first_start got=%b exp=1", bus.sm_start); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.sm_start !== 1'b0) begin failures++; $display("FAIL reset_async_start got=%b exp=0", bus.sm_start); end
      checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_async_gnt got=%b exp=0000", bus.gnt); end
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int n;
      logic [VW-1:0] a;
      a = {16{16'h0A5A}};
      eng_res = a;
      eng_lat = 40;
      @(negedge clk);
      bus.req = 4'b0100;
      n = 0;
      while (bus.gnt === 4'b0000 && n < 10) begin @(negedge clk); n++; end
      checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", bus.gnt); end
      checks++; if (bus.sm_data !== vec(2)) begin failures++; $display("FAIL single_sm_data got=%h exp=%h", bus.sm_data, vec(2)); end
      n = 0;
      while (bus.gnt === 4'b0100 && n < 200) begin
         if (bus.sm_vld === 1'b1) begin
            checks++; if (bus.sm_start !== 1'b0) begin failures++; $display("FAIL single_start_in_vld got=%b exp=0", bus.sm_start); end
         end
         n++;
         @(negedge clk);
      end
      checks++; if (n != 40) begin failures++; $display("FAIL single_gnt_len got=%0d exp=40", n); end
      checks++; if (bus.done !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=0100", bus.done); end
      checks++; if (bus.data !== a) begin failures++; $display("FAIL single_data got=%h exp=%h", bus.data, a); end
      checks++; if (bus.id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", bus.id); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", bus.err); end
      bus.req = '0;
      @(negedge clk);
      checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL single_done_width got=%b exp=0000", bus.done); end
      checks++; if (bus.sm_start !== 1'b0) begin failures++; $display("FAIL single_idle_start got=%b exp=0", bus.sm_start); end
   endtask

   task automatic test_round_robin();
      int n;
      int idle;
      logic [3:0] exp;
      do_reset();
      eng_lat = 4;
      eng_res = {16{16'h1111}};
      bus.req = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         exp = 4'b0001 << (s % 4);
         n = 0;
         while (bus.gnt === 4'b0000 && n < 10) begin @(negedge clk); n++; end
         checks++; if (bus.gnt !== exp) begin failures++; $display("FAIL rr_order svc=%0d got=%b exp=%b", s, bus.gnt, exp); end
         if (s < 4) begin
            n = 0;
            while (bus.sm_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            idle = 0;
            while (bus.sm_start === 1'b0 && idle < 20) begin
               idle++;
               @(negedge clk);
               if (idle == 1) begin
                  checks++; if (bus.done !== exp) begin failures++; $display("FAIL rr_done svc=%0d got=%b exp=%b", s, bus.done, exp); end
               end
            end
            checks++; if (idle != 3) begin failures++; $display("FAIL rr_gap svc=%0d got=%0d exp=3", s, idle); end
         end
      end
      bus.req = '0;
   endtask

   task automatic test_abort();
      int n;
      int low;
      int bad;
      do_reset();
      eng_lat = 0;
      bus.req = 4'b0110;
      n = 0;
      while (bus.gnt === 4'b0000 && n < 10) begin @(negedge clk); n++; end
      checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL abort_gnt got=%b exp=0010", bus.gnt); end
      repeat (9) @(negedge clk);
      bus.req = 4'b0100;
      @(negedge clk);
      n = 0; low = 0; bad = 0;
      while (bus.gnt !== 4'b0100 && n < 10) begin
         if (bus.done !== 4'b0000 || bus.err !== 1'b0) bad++;
         if (bus.sm_start === 1'b0) low++;
         n++;
         @(negedge clk);
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL abort_no_done_err got=%0d exp=0", bad); end
      checks++; if (low != 2) begin failures++; $display("FAIL abort_start_low got=%0d exp=2", low); end
      checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL abort_next_gnt got=%b exp=0100", bus.gnt); end
      checks++; if (bus.id !== 2'd0) begin failures++; $display("FAIL abort_id got=%0d exp=0", bus.id); end
      checks++; if (bus.data !== '0) begin failures++; $display("FAIL abort_data got=%h exp=0", bus.data); end
   endtask

   task automatic test_timeout();
      int n;
      logic [VW-1:0] b;
      do_reset();
      b = {16{16'h7B7B}};
      eng_res = b;
      eng_lat = 3;
      bus.req = 4'b1000;
      n = 0;
      while (bus.done === 4'b0000 && n < 20) begin @(negedge clk); n++; end
      checks++; if (bus.done !== 4'b1000) begin failures++; $display("FAIL tout_pre_done got=%b exp=1000", bus.done); end
      checks++; if (bus.data !== b) begin failures++; $display("FAIL tout_pre_data got=%h exp=%h", bus.data, b); end
      bus.req = '0;
      eng_lat = 0;
      @(negedge clk);
      bus.req = 4'b0011;
      n = 0;
      while (bus.gnt === 4'b0000 && n < 10) begin @(negedge clk); n++; end
      checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL tout_gnt got=%b exp=0001", bus.gnt); end
      n = 0;
      while (bus.gnt === 4'b0001 && n < 200) begin n++; @(negedge clk); end
      checks++; if (n != 64) begin failures++; $display("FAIL tout_run_len got=%0d exp=64", n); end
      checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL tout_err got=%b exp=1", bus.err); end
      checks++; if (bus.id !== 2'd0) begin failures++; $display("FAIL tout_id got=%0d exp=0", bus.id); end
      checks++; if (bus.data !== b) begin failures++; $display("FAIL tout_data_held got=%h exp=%h", bus.data, b); end
      checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL tout_done got=%b exp=0000", bus.done); end
      bus.req = 4'b0010;
      @(negedge clk);
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL tout_err_width got=%b exp=0", bus.err); end
      n = 0;
      while (bus.gnt === 4'b0000 && n < 10) begin @(negedge clk); n++; end
      checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL tout_next_gnt got=%b exp=0010", bus.gnt); end
      bus.req = '0;
   endtask

   task automatic test_simultaneous();
      int n;
      logic [VW-1:0] c;
      do_reset();
      c = {16{16'hC3C3}};
      eng_res = c;
      eng_lat = 64;
      bus.req = 4'b0001;
      n = 0;
      while (bus.gnt === 4'b0000 && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (bus.gnt === 4'b0001 && n < 200) begin
         n++;
         if (n == 64) begin
            checks++; if (bus.sm_vld !== 1'b1) begin failures++; $display("FAIL simul_vld got=%b exp=1", bus.sm_vld); end
            bus.req = '0;
         end
         @(negedge clk);
      end
      checks++; if (n != 64) begin failures++; $display("FAIL simul_run_len got=%0d exp=64", n); end
      checks++; if (bus.done !== 4'b0001) begin failures++; $display("FAIL simul_done got=%b exp=0001", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL simul_err got=%b exp=0", bus.err); end
      checks++; if (bus.data !== c) begin failures++; $display("FAIL simul_data got=%h exp=%h", bus.data, c); end
      checks++; if (bus.id !== 2'd0) begin failures++; $display("FAIL simul_id got=%0d exp=0", bus.id); end
      @(negedge clk);
      checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL simul_done_width got=%b exp=0000", bus.done); end
   endtask

   initial begin
      bus.req = '0;
      bus.req_data = '0;
      for (int k = 0; k < N_REQ; k++) bus.req_data[k*VW +: VW] = vec(k);
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_timeout();
      test_simultaneous();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
